// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer
//
// Purpose:
//   Serializes parallel words into a one-bit-per-clock stream for the
//   downstream 101 sequence detectors. Words arrive over a valid/ready
//   handshake. Back-to-back words stream with no gap. Between words, x
//   holds IDLE_BIT.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//   IDLE_BIT   level on x whenever no word is being shifted
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   data_in     parallel word to serialize
//   data_valid  data_in is presented this cycle
//   data_ready  a word is accepted at the next edge if data_valid = 1
//   x           serial bit stream (goes to detector x input)
//   bit_valid   x carries a data bit, not idle fill
//   last_bit    x carries the final bit of the current word
//   busy        a word is being shifted

module serial_bit_streamer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             in_shift;
  logic             at_last;
  logic             accept;
  logic             head_bit;
  logic [WIDTH-1:0] sreg_next;

  // Every output below is decoded from flops only, so nothing on the
  // input side can reach x combinationally.
  assign in_shift = (state == SHIFT);
  assign at_last  = in_shift && (bit_cnt == LAST_CNT);

  // The head of the register is the bit currently on the line. The
  // register moves toward that head by one place each cycle.
  assign head_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};

  // Ready is raised during the final bit so the next word can be loaded
  // on the same edge that retires the current one. Reset forces it low
  // so a word held on the inputs during reset is never taken.
  assign data_ready = !reset && (!in_shift || at_last);
  assign accept     = data_valid && data_ready;

  assign x         = in_shift ? head_bit : IDLE_BIT;
  assign bit_valid = in_shift;
  assign busy      = in_shift;
  assign last_bit  = at_last;

  // Load, shift and retire. An accept takes priority over everything
  // else. It can only happen while idle or on the final bit, so a reload
  // never cuts a word short. On the final bit without a new word, the
  // register is cleared so no residue survives into the idle period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      state   <= SHIFT;
      sreg    <= data_in;
      bit_cnt <= '0;
    end else if (in_shift) begin
      if (at_last) begin
        state   <= IDLE;
        sreg    <= '0;
        bit_cnt <= '0;
      end else begin
        sreg    <= sreg_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
